// File: rtl/uart_tx_fifo_engine_if.sv
// Bus between the register-file side (FIFO writes, frame config, flow
// control) and the UART transmit engine, plus the engine's status outputs.
interface uart_tx_fifo_engine_if #(
    parameter int MAX_DATA_W = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          tick_i;
    logic                          tx_en_i;
    logic                          wr_en_i;
    logic [MAX_DATA_W-1:0]         wr_data_i;
    logic [3:0]                    data_bits_i;
    logic                          parity_en_i;
    logic [1:0]                    parity_type_i;
    logic                          stop_bit_num_i;
    logic                          cts_ni;
    logic                          break_i;
    logic                          tx_o;
    logic                          busy_o;
    logic                          trans_fi_o;
    logic                          fifo_full_o;
    logic                          fifo_empty_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
    logic                          overflow_o;

    modport master (
        output tick_i, tx_en_i, wr_en_i, wr_data_i, data_bits_i, parity_en_i,
               parity_type_i, stop_bit_num_i, cts_ni, break_i,
        input  tx_o, busy_o, trans_fi_o, fifo_full_o, fifo_empty_o,
               fifo_level_o, overflow_o
    );

    modport slave (
        input  tick_i, tx_en_i, wr_en_i, wr_data_i, data_bits_i, parity_en_i,
               parity_type_i, stop_bit_num_i, cts_ni, break_i,
        output tx_o, busy_o, trans_fi_o, fifo_full_o, fifo_empty_o,
               fifo_level_o, overflow_o
    );
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine with TX FIFO. Frames are timed in oversample ticks,
// format (data length, parity, stop bits) is latched per frame, CTS gates
// frame starts, and break drives the line low for at least one frame time.
module uart_tx_fifo_engine #(
    parameter int MAX_DATA_W = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_fifo_engine_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TCK_W = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK, MARK
    } state_t;

    // ---------------- FIFO ----------------
    logic [MAX_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  full, empty, push, pop, ovf_q;

    // ---------------- engine ----------------
    state_t                state;
    logic                  tx_q, busy_q, fin_q;
    logic [TCK_W-1:0]      tick_cnt;
    logic [3:0]            bit_cnt;
    logic [MAX_DATA_W-1:0] word_q;
    logic [3:0]            nbits_q;
    logic                  par_en_q, stop2_q;
    logic [1:0]            par_type_q;
    logic                  par_bit, bit_end, brk_done;
    logic [3:0]            n_in;
    logic [15:0]           mask16, word_ext;
    logic [4:0]            frame_bits;

    function automatic logic [3:0] clamp_bits(input logic [3:0] v);
        if (v < 4'd5) return 4'd5;
        if (int'(v) > MAX_DATA_W) return 4'(MAX_DATA_W);
        return v;
    endfunction

    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign push     = bus.wr_en_i && !full;
    // A frame starts only from IDLE, and a pending break always wins.
    assign pop      = (state == IDLE) && !bus.break_i && bus.tx_en_i && !empty && !bus.cts_ni;

    assign n_in     = clamp_bits(bus.data_bits_i);
    assign mask16   = 16'((32'd1 << n_in) - 32'd1);
    assign word_ext = 16'(word_q);
    assign bit_end  = bus.tick_i && (tick_cnt == TCK_W'(OVS - 1));

    // Break length is one full frame in the format latched at break entry.
    assign frame_bits = 5'd1 + {1'b0, nbits_q} + {4'b0, par_en_q} + (stop2_q ? 5'd2 : 5'd1);
    assign brk_done   = ({1'b0, bit_cnt} >= frame_bits) ||
                        (bit_end && ({1'b0, bit_cnt} + 5'd1 >= frame_bits));

    // Unsent high bits were masked off at latch time, so parity covers exactly N bits.
    always_comb begin
        par_bit = 1'b0;
        case (par_type_q)
            2'b00:   par_bit = ^word_q;
            2'b01:   par_bit = ~^word_q;
            2'b10:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data_i;
    end

    // FIFO pointers, level and the dropped-write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en_i && full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Frame sequencer with registered line, busy and frame-done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            word_q     <= '0;
            nbits_q    <= 4'd5;
            par_en_q   <= 1'b0;
            par_type_q <= 2'b00;
            stop2_q    <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (state != IDLE && bus.tick_i)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (bus.break_i || pop) begin
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        nbits_q    <= n_in;
                        par_en_q   <= bus.parity_en_i;
                        par_type_q <= bus.parity_type_i;
                        stop2_q    <= bus.stop_bit_num_i;
                        if (bus.break_i) begin
                            state <= BREAK;
                        end else begin
                            state  <= START;
                            word_q <= mem[rd_ptr] & mask16[MAX_DATA_W-1:0];
                        end
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    tx_q    <= word_ext[0];
                    bit_cnt <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_cnt == nbits_q - 4'd1) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state <= PARITY;
                            tx_q  <= par_bit;
                        end else begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx_q    <= word_ext[bit_cnt + 4'd1];
                    end
                end
                PARITY: if (bit_end) begin
                    state   <= STOP;
                    tx_q    <= 1'b1;
                    bit_cnt <= '0;
                end
                STOP: if (bit_end) begin
                    if (bit_cnt == {3'b000, stop2_q}) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        fin_q  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                BREAK: begin
                    // bit_cnt counts completed bit times; saturates well past any frame length
                    if (bit_end && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
                    if (!bus.break_i && brk_done) begin
                        state    <= MARK;
                        tx_q     <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                MARK: if (bit_end) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_o         = tx_q;
    assign bus.busy_o       = busy_q;
    assign bus.trans_fi_o   = fin_q;
    assign bus.fifo_full_o  = full;
    assign bus.fifo_empty_o = empty;
    assign bus.fifo_level_o = level;
    assign bus.overflow_o   = ovf_q;
endmodule
